// File: rtl/riscv_mem_arb_pkg.sv
// Shared types and helpers for the data-memory / debug port arbiter.
package riscv_mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {GNT_CORE, GNT_DBG} gnt_t;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  // Natural alignment check; sizes wider than the data path are also faults.
  function automatic logic is_misaligned(input logic [2:0] adr,
                                         input logic [2:0] size,
                                         input int unsigned xlen);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = adr[0];
      SZ_W:    mis = |adr[1:0];
      SZ_D:    mis = |adr[2:0];
      default: mis = 1'b1;
    endcase
    if ((32'd8 << size) > xlen) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/riscv_mem_arb_timer.sv
// Per-access ack timeout counter; expired flags the last allowed BUSY cycle.
module riscv_mem_arb_timer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/riscv_dmem_dbg_arbiter.sv
// Shares one downstream data-memory port between the core LSU and the debug port.
module riscv_dmem_dbg_arbiter
  import riscv_mem_arb_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned PLEN    = 64,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  logic [2:0]      dmem_size,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_err,
  output logic            dmem_misaligned,

  input  logic            dbg_strb,
  input  logic            dbg_we,
  input  logic [PLEN-1:0] dbg_addr,
  input  logic [XLEN-1:0] dbg_dati,
  input  logic            dbg_stall,
  output logic [XLEN-1:0] dbg_dato,
  output logic            dbg_ack,

  output logic            mem_req,
  output logic [PLEN-1:0] mem_adr,
  output logic [XLEN-1:0] mem_d,
  output logic            mem_we,
  output logic [2:0]      mem_size,
  input  logic [XLEN-1:0] mem_q,
  input  logic            mem_ack,
  input  logic            mem_err
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(XLEN / 8));

  state_t state_q, state_d;
  gnt_t   last_gnt_q, last_gnt_d;
  gnt_t   owner_q, owner_d;
  gnt_t   pick;
  logic   core_mis;
  logic   tmo_expired;

  logic            mem_req_d, mem_we_d;
  logic [PLEN-1:0] mem_adr_d;
  logic [XLEN-1:0] mem_d_d, dmem_q_d, dbg_dato_d;
  logic [2:0]      mem_size_d;
  logic            dmem_ack_d, dmem_err_d, dmem_mis_d, dbg_ack_d;

  riscv_mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != BUSY),
    .en      (state_q == BUSY),
    .expired (tmo_expired)
  );

  assign core_mis = is_misaligned(dmem_adr[2:0], dmem_size, XLEN);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    pick       = GNT_CORE;
    mem_req_d  = mem_req;
    mem_adr_d  = mem_adr;
    mem_d_d    = mem_d;
    mem_we_d   = mem_we;
    mem_size_d = mem_size;
    dmem_q_d   = dmem_q;
    dbg_dato_d = dbg_dato;
    dmem_ack_d = 1'b0;
    dmem_err_d = 1'b0;
    dmem_mis_d = 1'b0;
    dbg_ack_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (dmem_req || dbg_strb) begin
          // Debug wins when alone, when the core is halted, or when it is its turn.
          if (dbg_strb && (!dmem_req || dbg_stall || last_gnt_q == GNT_CORE))
            pick = GNT_DBG;
          last_gnt_d = pick;
          owner_d    = pick;
          if (pick == GNT_DBG) begin
            state_d    = BUSY;
            mem_req_d  = 1'b1;
            mem_adr_d  = dbg_addr;
            mem_d_d    = dbg_dati;
            mem_we_d   = dbg_we;
            mem_size_d = MAX_SIZE;
          end else if (core_mis) begin
            state_d    = RESP;
            dmem_err_d = 1'b1;
            dmem_mis_d = 1'b1;
          end else begin
            state_d    = BUSY;
            mem_req_d  = 1'b1;
            mem_adr_d  = PLEN'(dmem_adr);
            mem_d_d    = dmem_d;
            mem_we_d   = dmem_we;
            mem_size_d = dmem_size;
          end
        end
      end

      BUSY: begin
        // Bus error beats a same-cycle ack; an ack beats a same-cycle timeout.
        if (mem_err || (!mem_ack && tmo_expired)) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (owner_q == GNT_CORE) begin
            dmem_err_d = 1'b1;
            dmem_q_d   = '0;
          end else begin
            dbg_ack_d  = 1'b1;
            dbg_dato_d = '1;
          end
        end else if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (owner_q == GNT_CORE) begin
            dmem_ack_d = 1'b1;
            dmem_q_d   = mem_q;
          end else begin
            dbg_ack_d  = 1'b1;
            dbg_dato_d = mem_q;
          end
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_gnt_q      <= GNT_DBG;
      owner_q         <= GNT_CORE;
      mem_req         <= 1'b0;
      mem_adr         <= '0;
      mem_d           <= '0;
      mem_we          <= 1'b0;
      mem_size        <= '0;
      dmem_q          <= '0;
      dbg_dato        <= '0;
      dmem_ack        <= 1'b0;
      dmem_err        <= 1'b0;
      dmem_misaligned <= 1'b0;
      dbg_ack         <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_gnt_q      <= last_gnt_d;
      owner_q         <= owner_d;
      mem_req         <= mem_req_d;
      mem_adr         <= mem_adr_d;
      mem_d           <= mem_d_d;
      mem_we          <= mem_we_d;
      mem_size        <= mem_size_d;
      dmem_q          <= dmem_q_d;
      dbg_dato        <= dbg_dato_d;
      dmem_ack        <= dmem_ack_d;
      dmem_err        <= dmem_err_d;
      dmem_misaligned <= dmem_mis_d;
      dbg_ack         <= dbg_ack_d;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_dbg_arbiter.sv
// Scoreboard bench for riscv_dmem_dbg_arbiter: directed stimulus, queued expectations.
module tb_riscv_dmem_dbg_arbiter;

  localparam int K_CORE_ACK = 0;
  localparam int K_CORE_ERR = 1;
  localparam int K_DBG_ACK  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_req, dmem_we, dbg_strb, dbg_we, dbg_stall;
  logic [63:0] dmem_adr, dmem_d, dbg_addr, dbg_dati, mem_q;
  logic [2:0]  dmem_size;
  logic        mem_ack, mem_err;
  logic [63:0] dmem_q, dbg_dato, mem_adr, mem_d;
  logic        dmem_ack, dmem_err, dmem_misaligned, dbg_ack;
  logic        mem_req, mem_we;
  logic [2:0]  mem_size;

  riscv_dmem_dbg_arbiter #(.XLEN(64), .PLEN(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .dmem_req(dmem_req), .dmem_adr(dmem_adr), .dmem_d(dmem_d), .dmem_we(dmem_we),
    .dmem_size(dmem_size), .dmem_q(dmem_q), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .dmem_misaligned(dmem_misaligned),
    .dbg_strb(dbg_strb), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_dati(dbg_dati),
    .dbg_stall(dbg_stall), .dbg_dato(dbg_dato), .dbg_ack(dbg_ack),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we),
    .mem_size(mem_size), .mem_q(mem_q), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic        mis;
    logic        chk;
    logic [63:0] data;
  } resp_t;

  typedef struct {
    logic [63:0] adr;
    logic [63:0] d;
    logic        we;
    logic [2:0]  size;
  } mreq_t;

  resp_t exp_rq[$];
  mreq_t exp_mq[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_r(input int kind, input logic mis, input logic chk, input logic [63:0] data);
    resp_t r;
    r.kind = kind; r.mis = mis; r.chk = chk; r.data = data;
    exp_rq.push_back(r);
  endtask

  task automatic exp_m(input logic [63:0] adr, input logic [63:0] d, input logic we,
                       input logic [2:0] size);
    mreq_t m;
    m.adr = adr; m.d = d; m.we = we; m.size = size;
    exp_mq.push_back(m);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for mem_req, answers after 'delay' cycles, returns in the response cycle.
  task automatic serve(input int delay, input logic [63:0] q, input logic ack, input logic err);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick(1);
      n++;
    end
    check("mem_req_seen", 64'(mem_req), 64'd1);
    tick(delay);
    mem_ack = ack; mem_err = err; mem_q = q;
    tick(1);
    mem_ack = 1'b0; mem_err = 1'b0; mem_q = '0;
    check("resp_latency", 64'(dmem_ack | dmem_err | dbg_ack), 64'd1);
  endtask

  // Response monitor
  resp_t r_act;
  int    act_kind;
  always @(negedge clk) begin
    if (!rst && (dmem_ack || dmem_err || dbg_ack)) begin
      if (exp_rq.size() == 0) begin
        check("unexpected_resp", 64'({dmem_ack, dmem_err, dbg_ack}), 64'd0);
      end else begin
        r_act = exp_rq.pop_front();
        act_kind = (dmem_ack && !dmem_err && !dbg_ack) ? K_CORE_ACK :
                   (dmem_err && !dmem_ack && !dbg_ack) ? K_CORE_ERR :
                   (dbg_ack && !dmem_ack && !dmem_err) ? K_DBG_ACK : 3;
        check("resp_kind", 64'(act_kind), 64'(r_act.kind));
        check("resp_misaligned", 64'(dmem_misaligned), 64'(r_act.mis));
        if (r_act.chk)
          check("resp_data", (r_act.kind == K_DBG_ACK) ? dbg_dato : dmem_q, r_act.data);
      end
    end
  end

  // Downstream request monitor
  logic  req_prev = 1'b0;
  mreq_t m_act;
  always @(negedge clk) begin
    if (!rst && mem_req && !req_prev) begin
      if (exp_mq.size() == 0) begin
        check("unexpected_mem_req", 64'(mem_req), 64'd0);
      end else begin
        m_act = exp_mq.pop_front();
        check("mem_adr", mem_adr, m_act.adr);
        check("mem_d", mem_d, m_act.d);
        check("mem_we", 64'(mem_we), 64'(m_act.we));
        check("mem_size", 64'(mem_size), 64'(m_act.size));
      end
    end
    req_prev = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  logic [63:0] mis_adr [4];
  logic [2:0]  mis_sz  [4];
  int          n;

  initial begin
    rst = 1'b1;
    dmem_req = 0; dmem_we = 0; dmem_adr = '0; dmem_d = '0; dmem_size = 3'd3;
    dbg_strb = 0; dbg_we = 0; dbg_addr = '0; dbg_dati = '0; dbg_stall = 0;
    mem_q = '0; mem_ack = 0; mem_err = 0;
    mis_adr[0] = 64'h1001; mis_sz[0] = 3'd1;
    mis_adr[1] = 64'h1002; mis_sz[1] = 3'd2;
    mis_adr[2] = 64'h1004; mis_sz[2] = 3'd3;
    mis_adr[3] = 64'h1000; mis_sz[3] = 3'd4;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_pulses", 64'({dmem_ack, dmem_err, dmem_misaligned, dbg_ack}), 64'd0);
    check("rst_dmem_q", dmem_q, 64'd0);
    check("rst_dbg_dato", dbg_dato, 64'd0);
    check("rst_mem_adr", mem_adr, 64'd0);

    // Contended: core first, then debug (round-robin), then remaining core
    exp_m(64'h100, 64'h0, 1'b0, 3'd3);
    exp_m(64'h200, 64'hAB, 1'b1, 3'd3);
    exp_m(64'h108, 64'h0, 1'b0, 3'd3);
    exp_r(K_CORE_ACK, 1'b0, 1'b1, 64'hA1);
    exp_r(K_DBG_ACK,  1'b0, 1'b1, 64'hB2);
    exp_r(K_CORE_ACK, 1'b0, 1'b1, 64'hC3);
    dmem_req = 1; dmem_adr = 64'h100; dmem_we = 0; dmem_size = 3'd3; dmem_d = '0;
    dbg_strb = 1; dbg_we = 1; dbg_addr = 64'h200; dbg_dati = 64'hAB;
    serve(2, 64'hA1, 1'b1, 1'b0);
    dmem_adr = 64'h108;
    serve(2, 64'hB2, 1'b1, 1'b0);
    dbg_strb = 0;
    serve(2, 64'hC3, 1'b1, 1'b0);
    dmem_req = 0;
    tick(1);

    // Debug-only write, leaves debug as last grant
    exp_m(64'h300, 64'h5A, 1'b1, 3'd3);
    exp_r(K_DBG_ACK, 1'b0, 1'b1, 64'h0);
    dbg_strb = 1; dbg_we = 1; dbg_addr = 64'h300; dbg_dati = 64'h5A;
    serve(1, 64'h0, 1'b1, 1'b0);
    dbg_strb = 0;
    tick(1);

    // Contended with dbg_stall: debug first despite being last granted
    exp_m(64'h310, 64'h0, 1'b0, 3'd3);
    exp_m(64'h118, 64'h0, 1'b0, 3'd3);
    exp_r(K_DBG_ACK,  1'b0, 1'b1, 64'hD4);
    exp_r(K_CORE_ACK, 1'b0, 1'b1, 64'hE5);
    dbg_stall = 1; dbg_strb = 1; dbg_we = 0; dbg_addr = 64'h310; dbg_dati = '0;
    dmem_req = 1; dmem_adr = 64'h118;
    serve(1, 64'hD4, 1'b1, 1'b0);
    dbg_strb = 0;
    serve(1, 64'hE5, 1'b1, 1'b0);
    dmem_req = 0; dbg_stall = 0;
    tick(1);

    // Core aligned read, ack 3 cycles after mem_req
    exp_m(64'h1000, 64'h0, 1'b0, 3'd3);
    exp_r(K_CORE_ACK, 1'b0, 1'b1, 64'hDEAD_BEEF);
    dmem_req = 1; dmem_adr = 64'h1000; dmem_size = 3'd3;
    serve(3, 64'hDEAD_BEEF, 1'b1, 1'b0);
    check("read_no_err", 64'(dmem_err), 64'd0);
    dmem_req = 0;
    tick(1);

    // Core write: dmem_q holds the captured mem_q
    exp_m(64'h2008, 64'h1122_3344_5566_7788, 1'b1, 3'd3);
    exp_r(K_CORE_ACK, 1'b0, 1'b1, 64'h55);
    dmem_req = 1; dmem_adr = 64'h2008; dmem_d = 64'h1122_3344_5566_7788; dmem_we = 1;
    serve(1, 64'h55, 1'b1, 1'b0);
    dmem_req = 0; dmem_we = 0; dmem_d = '0;
    tick(1);

    // Misaligned core requests never reach downstream
    for (int i = 0; i < 4; i++) begin
      exp_r(K_CORE_ERR, 1'b1, 1'b0, 64'h0);
      dmem_req = 1; dmem_adr = mis_adr[i]; dmem_size = mis_sz[i];
      tick(1);
      check("mis_err_c1", 64'(dmem_err & dmem_misaligned), 64'd1);
      check("mis_no_mem_req", 64'(mem_req), 64'd0);
      dmem_req = 0;
      tick(1);
      check("mis_no_mem_req_c2", 64'(mem_req), 64'd0);
    end

    // Aligned halfword passes its size through
    exp_m(64'h1002, 64'h0, 1'b0, 3'd1);
    exp_r(K_CORE_ACK, 1'b0, 1'b1, 64'h33);
    dmem_req = 1; dmem_adr = 64'h1002; dmem_size = 3'd1;
    serve(0, 64'h33, 1'b1, 1'b0);
    dmem_req = 0; dmem_size = 3'd3;
    tick(1);

    // Timeout: mem_req high 4 cycles, then dmem_err with dmem_q cleared
    exp_m(64'h4000, 64'h0, 1'b0, 3'd3);
    exp_r(K_CORE_ERR, 1'b0, 1'b1, 64'h0);
    dmem_req = 1; dmem_adr = 64'h4000;
    n = 0;
    tick(1);
    while (mem_req && n < 20) begin
      n++;
      tick(1);
    end
    check("timeout_req_cycles", 64'(n), 64'd4);
    check("timeout_err", 64'(dmem_err), 64'd1);
    dmem_req = 0;
    tick(1);

    // Normal access after timeout
    exp_m(64'h4008, 64'h0, 1'b0, 3'd3);
    exp_r(K_CORE_ACK, 1'b0, 1'b1, 64'h77);
    dmem_req = 1; dmem_adr = 64'h4008;
    serve(2, 64'h77, 1'b1, 1'b0);
    dmem_req = 0;
    tick(1);

    // Debug read with ack and err together
    exp_m(64'h500, 64'h0, 1'b0, 3'd3);
    exp_r(K_DBG_ACK, 1'b0, 1'b1, '1);
    dbg_strb = 1; dbg_we = 0; dbg_addr = 64'h500; dbg_dati = '0;
    serve(1, 64'h1234, 1'b1, 1'b1);
    dbg_strb = 0;
    tick(1);

    // Core bus error clears dmem_q
    exp_m(64'h600, 64'h0, 1'b0, 3'd3);
    exp_r(K_CORE_ERR, 1'b0, 1'b1, 64'h0);
    dmem_req = 1; dmem_adr = 64'h600;
    serve(2, 64'h99, 1'b0, 1'b1);
    dmem_req = 0;
    tick(1);

    exp_m(64'h800, 64'h0, 1'b0, 3'd3);
    exp_r(K_CORE_ACK, 1'b0, 1'b1, 64'h88);
    dmem_req = 1; dmem_adr = 64'h800;
    serve(1, 64'h88, 1'b1, 1'b0);
    dmem_req = 0;
    tick(1);

    // Reset while BUSY, then stray ack/err
    exp_m(64'h700, 64'h0, 1'b0, 3'd3);
    dmem_req = 1; dmem_adr = 64'h700;
    tick(2);
    check("busy_before_rst", 64'(mem_req), 64'd1);
    rst = 1; dmem_req = 0;
    tick(1);
    rst = 0;
    check("rst_busy_mem_req", 64'(mem_req), 64'd0);
    check("rst_busy_dmem_q", dmem_q, 64'd0);
    check("rst_busy_dbg_dato", dbg_dato, 64'd0);
    mem_ack = 1; mem_q = 64'hFF;
    tick(1);
    mem_ack = 0; mem_err = 1;
    tick(1);
    mem_err = 0; mem_q = '0;
    tick(2);
    check("stray_pulses", 64'({dmem_ack, dmem_err, dmem_misaligned, dbg_ack}), 64'd0);
    check("stray_mem_req", 64'(mem_req), 64'd0);
    check("stray_outputs", dmem_q | dbg_dato | mem_adr | mem_d, 64'd0);

    // Back to normal service
    exp_m(64'h900, 64'h0, 1'b0, 3'd3);
    exp_r(K_CORE_ACK, 1'b0, 1'b1, 64'h42);
    dmem_req = 1; dmem_adr = 64'h900;
    serve(1, 64'h42, 1'b1, 1'b0);
    dmem_req = 0;
    tick(3);

    check("sb_resp_drained", 64'(exp_rq.size()), 64'd0);
    check("sb_mem_drained", 64'(exp_mq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
